lcd_frame_writer: RTL and testbench
===================================

# lcd_frame_writer

Upstream stage of the monochrome picture display: it accepts an 8-bit pixel byte stream (1 bit per pixel, MSB = leftmost pixel), packs it into 132-bit rows and writes them into the 132×160 image RAM that the LCD serial controller reads. It owns the RAM write port (WE/Address/Data/ClockEn) and yields to the display side via a busy input. One full frame is 160 rows × 17 bytes.

## Interface
Parameters:
- ROW_BITS, 132, pixel bits per RAM row
- ROWS, 160, rows per frame
- ADDR_W, 8, RAM address width
- BYTES_PER_ROW, 17, ceil(ROW_BITS/8); derived and not overridden

Ports:
- clk_in  in  1  12 MHz system clock
- rst_n_in  in  1  reset, asynchronous, active-low
- in_data  in  8  pixel byte
- in_valid  in  1  in_data valid
- in_sof  in  1  qualifies in_data as the first byte of a frame
- in_ready  out  1  byte accepted when in_valid & in_ready
- ram_busy_in  in  1  display side owns the RAM this cycle; no write allowed
- ram_clk_en_out  out  1  RAM ClockEn, asserted only with ram_we_out
- ram_we_out  out  1  RAM WE
- ram_addr_out  out  ADDR_W  row address
- ram_data_out  out  ROW_BITS  packed row
- frame_done_out  out  1  one-cycle pulse after row ROWS-1 is written
- sync_err_out  out  1  one-cycle pulse when in_sof arrives mid-frame

## Operation
- States: S_COLLECT, S_WRITE.
- S_COLLECT: in_ready=1. Each accepted byte k (0..16) is packed:
  - k=0..15 go to bits [131-8k : 124-8k];
  - k=16: in_data[7:4] goes to bits [3:0], and in_data[3:0] is discarded.
  - byte_cnt increments per accepted byte. Acceptance of byte 16 moves the state to S_WRITE.
- S_WRITE: in_ready=0.
  - When ram_busy_in=0: ram_we_out=ram_clk_en_out=1 for exactly one cycle, with ram_addr_out=row and ram_data_out=packed row. The next state is S_COLLECT, byte_cnt=0, and row increments.
  - When ram_busy_in=1: the state holds with we/clk_en=0 and addr/data stable.
- Row wrap: after writing row ROWS-1, row becomes 0 and frame_done_out pulses.
- Accepted byte with in_sof=1:
  - It is treated as byte 0 of row 0, and any partial row is discarded.
  - If (row,byte_cnt) ≠ (0,0) at that time, sync_err_out pulses in the following cycle.
  - in_sof on a non-accepted cycle is ignored.
- Without in_sof, bytes continue row by row, so a free-running stream is legal.
- Width rules: row is ADDR_W bits and never exceeds ROWS-1. byte_cnt is 5 bits, range 0..16.

## Timing
- Reset values: in_ready=0 during reset and 1 from the first clock after release. All other outputs are 0; row=0, byte_cnt=0, state=S_COLLECT.
- Reset asserted mid-row or mid-write aborts immediately. Outputs drop to reset values asynchronously and the partial row is lost.
- Write latency: the row write occurs in the cycle after byte 16 is accepted, when not busy. The next byte is accepted one cycle later. Minimum 18 cycles/row; 2880 cycles/frame.
- frame_done_out is high in the cycle after the row-159 write cycle.
- sync_err_out is high in the cycle after the offending in_sof byte is accepted.
- ram_busy_in is sampled combinationally in S_WRITE; ram_we_out must never be 1 while ram_busy_in=1.
- When in_valid=0 the block idles in S_COLLECT with packed data held.

## Structure
- Package lcd_pkg holds:
  - ROW_BITS, ROWS, ADDR_W, BYTES_PER_ROW;
  - the state enum {S_COLLECT, S_WRITE};
  - the byte-to-bit-offset rule.
- Sub-module lcd_row_packer: byte_cnt plus the 132-bit packing register, with clear/load-byte inputs. The top level holds the FSM, the row counter and the output registers.

## Test plan
- Single row: 17 bytes 0xFF…0xFF, last 0xA5, in_sof on first, busy=0. Required: one write with addr=0, data=132'h…FF followed by low nibble 4'hA; in_ready low for exactly 1 cycle.
- Full frame: 2720 bytes with byte value = row index, busy=0. Required: 160 writes at addr 0..159 with correct data; frame_done pulses once, 1 cycle after the addr-159 write; the next byte targets addr 0.
- Busy stall: hold ram_busy_in=1 for 5 cycles as byte 16 is accepted. Required: no WE during busy; WE asserted in the first cycle busy=0; addr/data unchanged across the stall; in_ready=0 throughout.
- Resync: in_sof on byte 9 of row 3. Required: sync_err pulses once; the partial row is discarded; the next write is to addr 0 with the new bytes.
- Reset mid-write: assert rst_n_in=0 while in S_WRITE under busy. Required: WE=0 and all outputs 0 immediately; after release the first 17 bytes write addr 0.
- Backpressure gaps: random in_valid deasserts over 2 rows. Required: data identical to the gap-free run, and no byte lost or duplicated.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state type and byte placement rule for the LCD frame writer
package lcd_pkg;

   localparam int ROW_BITS      = 132;
   localparam int ROWS          = 160;
   localparam int ADDR_W        = 8;
   localparam int BYTES_PER_ROW = (ROW_BITS + 7) / 8;

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_WRITE   = 1'b1
   } state_e;

   // Bytes fill a row from the MSB downward, so byte k lands with its LSB at
   // row_bits-8(k+1). The final byte of a 132-bit row goes negative here and
   // is handled as a partial (upper-nibble-only) byte by the packer.
   function automatic int byte_lsb(input int row_bits, input int k);
      return row_bits - 8 * (k + 1);
   endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// rtl/lcd_frame_writer_if.sv - pixel byte stream handshake between source and frame writer
interface lcd_frame_writer_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_sof;
   logic       in_ready;

   modport master (output in_data, output in_valid, output in_sof, input in_ready);
   modport slave  (input in_data, input in_valid, input in_sof, output in_ready);

endinterface

// File: rtl/lcd_row_packer.sv
// rtl/lcd_row_packer.sv - byte counter and row register that packs pixel bytes MSB-first
module lcd_row_packer #(
   parameter int ROW_W   = 132,
   parameter int N_BYTES = 17
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             restart_i,
   input  logic [7:0]       byte_i,
   output logic [4:0]       byte_cnt_o,
   output logic             last_o,
   output logic [ROW_W-1:0] row_o
);
   import lcd_pkg::*;

   // Pixel bits left over for the final byte of a row (4 for 132-bit rows).
   localparam int         REM  = ROW_W - 8 * (N_BYTES - 1);
   localparam logic [4:0] LAST = 5'(N_BYTES - 1);

   logic [4:0]       cnt_q, cnt_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [4:0]       slot;
   logic [7:0]       shift;
   logic [ROW_W-1:0] byte_ext;
   logic [ROW_W-1:0] byte_mask;

   // Place the incoming byte at its slot; a restart forces slot 0 and drops the partial row's count.
   always_comb begin
      slot      = restart_i ? 5'd0 : cnt_q;
      shift     = 8'(byte_lsb(ROW_W, int'(slot)));
      byte_ext  = ROW_W'(byte_i) << shift;
      byte_mask = ROW_W'(8'hFF) << shift;
      cnt_d     = cnt_q;
      row_d     = row_q;
      if (load_i) begin
         // Count saturates on the last slot; the writer clears it after the RAM write.
         cnt_d = (slot == LAST) ? slot : slot + 5'd1;
         if (slot == LAST) begin
            row_d = {row_q[ROW_W-1:REM], byte_i[7 -: REM]};
         end else begin
            row_d = (row_q & ~byte_mask) | byte_ext;
         end
      end else if (clear_i) begin
         cnt_d = '0;
      end
   end

   // Count and row storage; reset discards any partial row.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         row_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         row_q <= row_d;
      end
   end

   assign byte_cnt_o = cnt_q;
   assign last_o     = (cnt_q == LAST);
   assign row_o      = row_q;

endmodule

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - packs a pixel byte stream into rows and writes them into the LCD image RAM
module lcd_frame_writer #(
   parameter int ROW_BITS = lcd_pkg::ROW_BITS,
   parameter int ROWS     = lcd_pkg::ROWS,
   parameter int ADDR_W   = lcd_pkg::ADDR_W
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   lcd_frame_writer_if.slave   pix,
   input  logic                ram_busy_in,
   output logic                ram_clk_en_out,
   output logic                ram_we_out,
   output logic [ADDR_W-1:0]   ram_addr_out,
   output logic [ROW_BITS-1:0] ram_data_out,
   output logic                frame_done_out,
   output logic                sync_err_out
);
   localparam int                BYTES_PER_ROW = (ROW_BITS + 7) / 8;
   localparam logic [ADDR_W-1:0] ROW_LAST      = ADDR_W'(ROWS - 1);

   import lcd_pkg::*;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   row_q, row_d;
   logic                ready_q;
   logic                frame_done_q, frame_done_d;
   logic                sync_err_q, sync_err_d;
   logic                accept;
   logic                we;
   logic                pk_load, pk_restart, pk_clear, pk_last;
   logic [4:0]          byte_cnt;
   logic [ROW_BITS-1:0] packed_row;

   lcd_row_packer #(
      .ROW_W   (ROW_BITS),
      .N_BYTES (BYTES_PER_ROW)
   ) u_packer (
      .clk_i      (clk_in),
      .rst_n_i    (rst_n_in),
      .clear_i    (pk_clear),
      .load_i     (pk_load),
      .restart_i  (pk_restart),
      .byte_i     (pix.in_data),
      .byte_cnt_o (byte_cnt),
      .last_o     (pk_last),
      .row_o      (packed_row)
   );

   assign accept = pix.in_valid & ready_q;

   // Collect bytes until the row is full, then hold the row until the display side frees the RAM.
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      we           = 1'b0;
      pk_load      = 1'b0;
      pk_restart   = 1'b0;
      pk_clear     = 1'b0;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      case (state_q)
         S_COLLECT: begin
            if (accept) begin
               pk_load = 1'b1;
               if (pix.in_sof) begin
                  // Start-of-frame realigns to row 0; flag it unless we were already aligned.
                  pk_restart = 1'b1;
                  row_d      = '0;
                  sync_err_d = (row_q != '0) || (byte_cnt != '0);
               end else if (pk_last) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (!ram_busy_in) begin
               we       = 1'b1;
               pk_clear = 1'b1;
               state_d  = S_COLLECT;
               if (row_q == ROW_LAST) begin
                  row_d        = '0;
                  frame_done_d = 1'b1;
               end else begin
                  row_d = row_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = S_COLLECT;
      endcase
   end

   // State, row counter and registered status outputs; ready follows the next state so it is low in reset.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= S_COLLECT;
         row_q        <= '0;
         ready_q      <= 1'b0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         ready_q      <= (state_d == S_COLLECT);
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign pix.in_ready   = ready_q;
   assign ram_we_out     = we;
   assign ram_clk_en_out = we;
   assign ram_addr_out   = row_q;
   assign ram_data_out   = packed_row;
   assign frame_done_out = frame_done_q;
   assign sync_err_out   = sync_err_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb/tb_lcd_frame_writer.sv - self-checking bench for lcd_frame_writer against a queue-based row model
module tb_lcd_frame_writer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         busy;
   logic         ram_clk_en, ram_we, fd, se;
   logic [7:0]   ram_addr;
   logic [131:0] ram_data;

   always #5 clk = ~clk;

   lcd_frame_writer_if pix();

   lcd_frame_writer dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .pix            (pix),
      .ram_busy_in    (busy),
      .ram_clk_en_out (ram_clk_en),
      .ram_we_out     (ram_we),
      .ram_addr_out   (ram_addr),
      .ram_data_out   (ram_data),
      .frame_done_out (fd),
      .sync_err_out   (se)
   );

   typedef struct {
      int           addr;
      logic [131:0] data;
      int           cyc;
   } wr_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         acc_cyc = 0;
   int         mrow = 0;
   int         exp_sync = 0;
   wr_t        got_q[$];
   wr_t        exp_q[$];
   int         fd_q[$];
   int         se_q[$];
   logic [7:0] part[$];

   task automatic chk(input string tag, input logic [131:0] got, input logic [131:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Row image = the 17 bytes concatenated, minus the low nibble of the last one.
   function automatic logic [131:0] pack_row(input logic [7:0] b[$]);
      logic [135:0] cat = '0;
      foreach (b[i]) cat = {cat[127:0], b[i]};
      return cat[135:4];
   endfunction

   task automatic model_byte(input logic [7:0] b, input logic sof);
      if (sof) begin
         if (mrow != 0 || part.size() != 0) exp_sync++;
         part.delete();
         mrow = 0;
      end
      part.push_back(b);
      if (part.size() == 17) begin
         exp_q.push_back('{mrow, pack_row(part), 0});
         mrow = (mrow + 1) % 160;
         part.delete();
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (ram_we || ram_clk_en) begin
         chk("we_clken_busy", 132'({ram_we, ram_clk_en, busy}), 132'(3'b110));
         got_q.push_back('{int'(ram_addr), ram_data, cyc});
      end
      if (fd) fd_q.push_back(cyc);
      if (se) se_q.push_back(cyc);
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic sof);
      int n = 0;
      pix.in_data  = b;
      pix.in_valid = 1'b1;
      pix.in_sof   = sof;
      while (!pix.in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("ready_timeout", 132'(pix.in_ready), 132'(1));
      @(posedge clk);
      #1;
      acc_cyc      = cyc + 1;
      pix.in_valid = 1'b0;
      pix.in_sof   = 1'b0;
      model_byte(b, sof);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      busy         = 1'b0;
      pix.in_valid = 1'b0;
      pix.in_sof   = 1'b0;
      wait_cycles(2);
      rst_n    = 1'b1;
      mrow     = 0;
      exp_sync = 0;
      part.delete();
      got_q.delete();
      exp_q.delete();
      fd_q.delete();
      se_q.delete();
      wait_cycles(1);
   endtask

   task automatic check_writes();
      chk("write_count", 132'(got_q.size()), 132'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk("write_addr", 132'(got_q[i].addr), 132'(exp_q[i].addr));
         chk("write_data", got_q[i].data, exp_q[i].data);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_wr;
      int last_wr;
      int sof_cyc;
      rst_n        = 1'b0;
      busy         = 1'b0;
      pix.in_valid = 1'b0;
      pix.in_sof   = 1'b0;
      pix.in_data  = 8'h00;

      // Reset values
      @(posedge clk);
      #1;
      chk("rst_ready", 132'(pix.in_ready), 132'(0));
      chk("rst_we", 132'(ram_we), 132'(0));
      chk("rst_clken", 132'(ram_clk_en), 132'(0));
      chk("rst_addr", 132'(ram_addr), 132'(0));
      chk("rst_data", ram_data, 132'(0));
      chk("rst_frame_done", 132'(fd), 132'(0));
      chk("rst_sync_err", 132'(se), 132'(0));
      rst_n = 1'b1;
      #1;
      chk("ready_before_clk", 132'(pix.in_ready), 132'(0));
      wait_cycles(1);
      chk("ready_after_release", 132'(pix.in_ready), 132'(1));

      // Single row: FF x16 then A5, SOF on the first byte
      send(8'hFF, 1'b1);
      for (int k = 1; k < 16; k++) send(8'hFF, 1'b0);
      send(8'hA5, 1'b0);
      chk("single_ready_low", 132'(pix.in_ready), 132'(0));
      chk("single_we", 132'(ram_we), 132'(1));
      chk("single_addr", 132'(ram_addr), 132'(0));
      chk("single_data", ram_data, {{128{1'b1}}, 4'hA});
      wait_cycles(1);
      chk("single_ready_back", 132'(pix.in_ready), 132'(1));
      chk("single_we_once", 132'(ram_we), 132'(0));
      check_writes();
      chk("single_no_sync_err", 132'(se_q.size()), 132'(0));

      // Full frame: every byte of row r is r
      do_reset();
      for (int r = 0; r < 160; r++)
         for (int k = 0; k < 17; k++) send(8'(r), 1'b0);
      wait_cycles(3);
      chk("frame_write_count", 132'(got_q.size()), 132'(160));
      if (got_q.size() == 160) begin
         first_wr = got_q[0].cyc;
         last_wr  = got_q[159].cyc;
         chk("frame_row_period", 132'(last_wr - first_wr), 132'(159 * 18));
         chk("frame_done_count", 132'(fd_q.size()), 132'(1));
         if (fd_q.size() > 0) chk("frame_done_cycle", 132'(fd_q[0]), 132'(last_wr + 1));
      end
      check_writes();
      for (int k = 0; k < 17; k++) send(8'($urandom()), 1'b0);
      wait_cycles(3);
      check_writes();
      chk("frame_no_sync_err", 132'(se_q.size()), 132'(0));

      // Busy stall across the write of a row
      do_reset();
      for (int k = 0; k < 16; k++) send(8'($urandom()), 1'b0);
      busy = 1'b1;
      send(8'($urandom()), 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_we", 132'(ram_we), 132'(0));
         chk("stall_ready", 132'(pix.in_ready), 132'(0));
         if (exp_q.size() > 0) begin
            chk("stall_addr", 132'(ram_addr), 132'(exp_q[0].addr));
            chk("stall_data", ram_data, exp_q[0].data);
         end
         wait_cycles(1);
      end
      busy = 1'b0;
      #1;
      chk("stall_release_we", 132'(ram_we), 132'(1));
      wait_cycles(2);
      check_writes();

      // Resync: SOF arrives on byte 9 of row 3
      do_reset();
      for (int i = 0; i < 3 * 17 + 9; i++) send(8'($urandom()), 1'b0);
      send(8'($urandom()), 1'b1);
      sof_cyc = acc_cyc;
      for (int k = 1; k < 17; k++) send(8'($urandom()), 1'b0);
      wait_cycles(3);
      chk("resync_err_count", 132'(se_q.size()), 132'(exp_sync));
      if (se_q.size() > 0) chk("resync_err_cycle", 132'(se_q[0]), 132'(sof_cyc));
      check_writes();

      // Reset while a write is held off by busy
      do_reset();
      for (int k = 0; k < 16; k++) send(8'($urandom()), 1'b0);
      busy = 1'b1;
      send(8'($urandom()), 1'b0);
      wait_cycles(1);
      rst_n = 1'b0;
      #1;
      chk("midrst_we", 132'(ram_we), 132'(0));
      chk("midrst_clken", 132'(ram_clk_en), 132'(0));
      chk("midrst_ready", 132'(pix.in_ready), 132'(0));
      chk("midrst_addr", 132'(ram_addr), 132'(0));
      chk("midrst_data", ram_data, 132'(0));
      chk("midrst_status", 132'({fd, se}), 132'(0));
      wait_cycles(2);
      chk("midrst_no_write", 132'(got_q.size()), 132'(0));
      exp_q.delete();
      part.delete();
      mrow = 0;
      busy  = 1'b0;
      rst_n = 1'b1;
      wait_cycles(1);
      for (int k = 0; k < 17; k++) send(8'($urandom()), 1'b0);
      wait_cycles(3);
      check_writes();

      // Backpressure: random gaps in in_valid over two rows
      do_reset();
      for (int i = 0; i < 34; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         send(8'($urandom()), 1'b0);
      end
      wait_cycles(3);
      check_writes();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
